// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte transmitter: FSM state encoding,
// default timing parameters and a counter-width helper.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Never returns zero so single-value counters still get a real register.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_byte_transmitter_baud.sv
// Bit-period counter for the UART transmitter; bit_tick marks the last
// clock cycle of every bit while enabled.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_tick
);

    localparam int            CW   = cntWidth(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_baudCnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_baudCnt <= '0;
        end else if (i_clear) begin
            r_baudCnt <= '0;
        end else if (i_enable) begin
            if (r_baudCnt == LAST) begin
                r_baudCnt <= '0;
            end else begin
                r_baudCnt <= r_baudCnt + ONE;
            end
        end
    end

    assign o_bit_tick = i_enable && !i_clear && (r_baudCnt == LAST);

endmodule

// File: rtl/uart_byte_transmitter.sv
// UART byte transmitter: start bit, LSB-first data, optional even parity
// (enabled by defining UART_TX_PARITY_EN), stop bit. All outputs registered.
module uart_byte_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_send_pulse,
    input  logic                 i_reset_pulse,
    input  logic [DATA_BITS-1:0] i_data_in,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int               IDX_W    = cntWidth(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bitIdx;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_bitTick;
    logic                 w_clear;
    logic                 w_enable;
    logic [DATA_BITS-1:0] w_nextShift;

    // The counter sits at zero throughout IDLE so the start bit gets a full period.
    assign w_clear     = (r_state == ST_IDLE) || i_reset_pulse;
    assign w_enable    = (r_state != ST_IDLE);
    assign w_nextShift = r_shift >> 1;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_clear),
        .i_enable  (w_enable),
        .o_bit_tick(w_bitTick)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitIdx <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (i_reset_pulse) begin
            r_state  <= ST_IDLE;
            r_bitIdx <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_send_pulse) begin
                        r_shift  <= i_data_in;
                        r_bitIdx <= '0;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_START;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^i_data_in;
`endif
                    end
                end
                ST_START: begin
                    if (w_bitTick) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bitTick) begin
                        if (r_bitIdx == LAST_IDX) begin
                            r_bitIdx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx     <= r_parity;
                            r_state  <= ST_PARITY;
`else
                            r_tx     <= 1'b1;
                            r_state  <= ST_STOP;
`endif
                        end else begin
                            r_shift  <= w_nextShift;
                            r_tx     <= w_nextShift[0];
                            r_bitIdx <= r_bitIdx + IDX_ONE;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bitTick) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bitTick) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Scoreboard bench for uart_byte_transmitter: stimulus queues expected frames,
// a line monitor decodes tx/busy/done and compares. Honours UART_TX_PARITY_EN.
module tb_uart_byte_transmitter;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * CPB;
    localparam int MAX_WAIT     = 200;

    typedef struct {
        logic [7:0] data;
        bit         aborted;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       sendPulse;
    logic       resetPulse;
    logic [7:0] dataIn;
    logic       tx;
    logic       busy;
    logic       done;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    logic samples[$];
    bit   inFrame = 0;

    uart_byte_transmitter #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_send_pulse (sendPulse),
        .i_reset_pulse(resetPulse),
        .i_data_in    (dataIn),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected line pattern derived from the frame format: bit k of the vector is the k-th bit period.
    function automatic logic [FRAME_BITS-1:0] expectedFrame(input logic [7:0] d);
        logic [FRAME_BITS-1:0] v;
        v = '0;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        v[9] = ($countones(d) % 2) == 1;
`endif
        v[FRAME_BITS-1] = 1'b1;
        return v;
    endfunction

    task automatic scoreFrame();
        exp_t                  e;
        logic [FRAME_BITS-1:0] obs;
        int                    unstable;
        if (expQ.size() == 0) begin
            checkOutput("unexpected_frame", 32'(samples.size()), 0);
            return;
        end
        e = expQ.pop_front();
        if (e.aborted) begin
            checkOutput("abort_done", {31'd0, done}, 0);
            checkOutput("abort_tx", {31'd0, tx}, 1);
            return;
        end
        checkOutput("done_pulse", {31'd0, done}, 1);
        checkOutput("frame_len", 32'(samples.size()), FRAME_CYCLES);
        if (samples.size() == FRAME_CYCLES) begin
            unstable = 0;
            obs = '0;
            for (int b = 0; b < FRAME_BITS; b++) begin
                obs[b] = samples[b*CPB + CPB/2];
                for (int c = 0; c < CPB; c++)
                    if (samples[b*CPB + c] !== obs[b]) unstable++;
            end
            checkOutput("frame_bits", 32'(obs), 32'(expectedFrame(e.data)));
            checkOutput("bit_stable", 32'(unstable), 0);
        end
    endtask

    // Line monitor: records tx every cycle busy is high and scores when busy falls.
    always @(negedge clk) begin
        if (reset) begin
            inFrame = 0;
            samples.delete();
            expQ.delete();
        end else if (!inFrame) begin
            if (done) checkOutput("spurious_done", {31'd0, done}, 0);
            if (busy) begin
                inFrame = 1;
                samples.delete();
                samples.push_back(tx);
            end
        end else if (busy) begin
            if (done) checkOutput("done_while_busy", {31'd0, done}, 0);
            samples.push_back(tx);
            if (samples.size() > FRAME_CYCLES + 8) begin
                checkOutput("frame_timeout", 32'(samples.size()), FRAME_CYCLES);
                inFrame = 0;
            end
        end else begin
            inFrame = 0;
            scoreFrame();
        end
    end

    task automatic pushExpected(input logic [7:0] d, input bit aborted);
        exp_t e;
        e.data = d;
        e.aborted = aborted;
        expQ.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge following the sampling edge.
    task automatic applyStimulus(input logic [7:0] d);
        sendPulse = 1'b1;
        dataIn = d;
        @(negedge clk);
        sendPulse = 1'b0;
        dataIn = 8'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= MAX_WAIT) checkOutput("wait_idle_timeout", 32'(n), 0);
    endtask

    task automatic waitDone();
        int n = 0;
        @(negedge clk);
        while (!done && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= MAX_WAIT) checkOutput("wait_done_timeout", 32'(n), 0);
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b1;
        sendPulse = 1'b0;
        resetPulse = 1'b0;
        dataIn = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", {31'd0, tx}, 1);
        checkOutput("reset_busy", {31'd0, busy}, 0);
        checkOutput("reset_done", {31'd0, done}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] basic frame 8'hA5");
        pushExpected(8'hA5, 0);
        applyStimulus(8'hA5);
        checkOutput("start_latency_tx", {31'd0, tx}, 0);
        checkOutput("start_latency_busy", {31'd0, busy}, 1);
        waitIdle();

        $display("[TB] abort in data bit 3, then 8'h3C");
        pushExpected(8'h96, 1);
        applyStimulus(8'h96);
        repeat (4*CPB + 1) @(negedge clk);
        resetPulse = 1'b1;
        @(negedge clk);
        resetPulse = 1'b0;
        checkOutput("abort_tx_now", {31'd0, tx}, 1);
        checkOutput("abort_busy_now", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        pushExpected(8'h3C, 0);
        applyStimulus(8'h3C);
        waitIdle();

        $display("[TB] send while busy is ignored");
        pushExpected(8'h00, 0);
        applyStimulus(8'h00);
        repeat (10) @(negedge clk);
        applyStimulus(8'hFF);
        waitIdle();
        repeat (2) @(negedge clk);

        $display("[TB] send and reset_pulse together");
        sendPulse = 1'b1;
        resetPulse = 1'b1;
        dataIn = 8'h81;
        @(negedge clk);
        sendPulse = 1'b0;
        resetPulse = 1'b0;
        checkOutput("both_tx", {31'd0, tx}, 1);
        checkOutput("both_busy", {31'd0, busy}, 0);
        repeat (CPB) @(negedge clk);
        checkOutput("both_busy_later", {31'd0, busy}, 0);

        $display("[TB] back-to-back and parity patterns");
        pushExpected(8'h07, 0);
        applyStimulus(8'h07);
        waitDone();
        pushExpected(8'h55, 0);
        applyStimulus(8'h55);
        checkOutput("b2b_tx", {31'd0, tx}, 0);
        checkOutput("b2b_busy", {31'd0, busy}, 1);
        waitDone();
        pushExpected(8'h03, 0);
        applyStimulus(8'h03);
        waitIdle();

        $display("[TB] randomized frames");
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            pushExpected(d, 0);
            applyStimulus(d);
            if ($urandom_range(0, 1) == 1) begin
                waitDone();
            end else begin
                waitIdle();
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
        end
        waitIdle();

        $display("[TB] async reset mid-frame");
        pushExpected(8'hC3, 0);
        applyStimulus(8'hC3);
        repeat (2*CPB + 1) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_tx", {31'd0, tx}, 1);
        checkOutput("async_reset_busy", {31'd0, busy}, 0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        pushExpected(8'h5A, 0);
        applyStimulus(8'h5A);
        waitIdle();

        repeat (5) @(negedge clk);
        checkOutput("queue_empty", 32'(expQ.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
